// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux and IF/ID register.
// Optional macro IRQ_SYNC_EN puts irq through a 2-flop synchroniser before use.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        irq_out,
  output logic        valid_out
);

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        irq;
    logic        valid;
  } ifid_t;

  localparam logic [31:0] RESET_PC4 = {RESET_PC[31], RESET_PC[30:0] + 31'd4};
  localparam ifid_t IFID_RST = '{ins: 32'd0, pc: RESET_PC, pc4: RESET_PC4, irq: 1'b0, valid: 1'b0};
  localparam ifid_t BUBBLE   = '0;

  logic [31:0] pc, pc_nxt, pc_inc;
  ifid_t       ifid, ifid_nxt;
  logic        irq_eff, irq_take;

`ifdef IRQ_SYNC_EN
  logic [1:0] irq_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_sync <= '0;
    else        irq_sync <= {irq_sync[0], irq};
  end

  assign irq_eff = irq_sync[1];
`else
  assign irq_eff = irq;
`endif

  // Bit 31 is the supervisor flag: it never takes a carry from the increment.
  assign pc_inc   = {pc[31], pc[30:0] + 31'd4};
  assign irq_take = irq_eff & ~pc[31];

  always_comb begin
    pc_nxt   = pc;
    ifid_nxt = ifid;
    if (redirect_en) begin
      pc_nxt   = {redirect_pc[31:2], 2'b00};
      ifid_nxt = BUBBLE;
    end else if (stall) begin
      if (flush) ifid_nxt = BUBBLE;
    end else if (irq_take) begin
      // Interrupt entry carries the un-executed PC as the return address.
      pc_nxt   = IRQ_VEC;
      ifid_nxt = '{ins: 32'd0, pc: pc, pc4: pc_inc, irq: 1'b1, valid: 1'b1};
    end else if (flush) begin
      pc_nxt   = pc_inc;
      ifid_nxt = BUBBLE;
    end else begin
      pc_nxt   = pc_inc;
      ifid_nxt = '{ins: imem_rdata, pc: pc, pc4: pc_inc, irq: 1'b0, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      ifid <= IFID_RST;
    end else begin
      pc   <= pc_nxt;
      ifid <= ifid_nxt;
    end
  end

  assign imem_addr = pc;
  assign ins_out   = ifid.ins;
  assign pc_out    = ifid.pc;
  assign pc4_out   = ifid.pc4;
  assign irq_out   = ifid.irq;
  assign valid_out = ifid.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + random bench for if_fetch_stage; expected IF/ID contents are queued
// when a cycle's inputs are driven and compared after the clock edge.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
`ifdef IRQ_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect_en = 1'b0, irq = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, ins_out, pc_out, pc4_out;
  logic        irq_out, valid_out;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        irq;
    logic        valid;
  } slot_t;

  typedef struct packed {
    slot_t       slot;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  slot_t       m_slot;
  logic        m_s1, m_s2;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  function automatic logic [31:0] inc(input logic [31:0] a);
    return {a[31], a[30:0] + 31'd4};
  endfunction

  assign imem_rdata = rom(imem_addr);

  if_fetch_stage #(.RESET_PC(RESET_PC), .IRQ_VEC(IRQ_VEC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .irq         (irq),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ins_out     (ins_out),
    .pc_out      (pc_out),
    .pc4_out     (pc4_out),
    .irq_out     (irq_out),
    .valid_out   (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input slot_t s, input logic [31:0] pc);
    chk({tag, ".imem_addr"}, imem_addr, pc);
    chk({tag, ".ins_out"},   ins_out,   s.ins);
    chk({tag, ".pc_out"},    pc_out,    s.pc);
    chk({tag, ".pc4_out"},   pc4_out,   s.pc4);
    chk({tag, ".irq_out"},   {31'd0, irq_out},   {31'd0, s.irq});
    chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, s.valid});
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_slot = '{ins: 32'd0, pc: RESET_PC, pc4: 32'h8000_0004, irq: 1'b0, valid: 1'b0};
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
  task automatic step(input logic st, input logic fl, input logic re,
                      input logic [31:0] rpc, input logic iq);
    logic        eff;
    logic [31:0] npc;
    slot_t       ns;
    exp_t        e;
    stall = st; flush = fl; redirect_en = re; redirect_pc = rpc; irq = iq;
`ifdef IRQ_SYNC_EN
    eff = m_s2;
`else
    eff = iq;
`endif
    npc = m_pc;
    ns  = m_slot;
    if (re) begin
      npc = rpc & 32'hFFFF_FFFC;
      ns  = '0;
    end else if (st) begin
      if (fl) ns = '0;
    end else if (eff && !m_pc[31]) begin
      npc = IRQ_VEC;
      ns  = '{ins: 32'd0, pc: m_pc, pc4: inc(m_pc), irq: 1'b1, valid: 1'b1};
    end else if (fl) begin
      npc = inc(m_pc);
      ns  = '0;
    end else begin
      npc = inc(m_pc);
      ns  = '{ins: rom(m_pc), pc: m_pc, pc4: inc(m_pc), irq: 1'b0, valid: 1'b1};
    end
    sb.push_back('{slot: ns, npc: npc});
    m_pc   = npc;
    m_slot = ns;
    m_s2   = m_s1;
    m_s1   = iq;
    @(posedge clk);
    #1;
    n_asrt++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_outputs("step", e.slot, e.npc);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] rt;
    // Reset held across early edges: outputs must show reset values.
    #12;
    model_reset();
    check_outputs("reset", m_slot, RESET_PC);
    #1 reset = 1'b1;

    chk("first_addr", imem_addr, 32'h8000_0000);
    step(0, 0, 0, 0, 0);
    chk("seq1_addr", imem_addr, 32'h8000_0004);
    chk("seq1_ins", ins_out, 32'h2000_0000);
    chk("seq1_valid", {31'd0, valid_out}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("seq2_addr", imem_addr, 32'h8000_0008);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("stall_addr", imem_addr, 32'h8000_0008);
    chk("stall_pc_out", pc_out, 32'h8000_0004);
    chk("stall_ins", ins_out, 32'h2000_0001);
    step(0, 0, 0, 0, 0);
    chk("resume_pc_out", pc_out, 32'h8000_0008);

    step(1, 1, 1, 32'h0000_0103, 1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_ins", ins_out, 32'h0);
    chk("redir_valid", {31'd0, valid_out}, 32'd0);

    step(0, 0, 1, 32'h0000_0040, 0);
`ifdef IRQ_SYNC_EN
    step(0, 0, 0, 0, 0);
`else
    step(0, 0, 0, 0, 1);
    chk("irq_addr", imem_addr, 32'h8000_0004);
    chk("irq_out", {31'd0, irq_out}, 32'd1);
    chk("irq_pc_out", pc_out, 32'h0000_0040);
    chk("irq_ins", ins_out, 32'h0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("irq_no_reentry", {31'd0, irq_out}, 32'd0);
`endif
    step(0, 0, 0, 0, 0);

    step(0, 0, 1, 32'h8000_0010, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("irq_masked", {31'd0, irq_out}, 32'd0);
    chk("irq_masked_addr", imem_addr, 32'h8000_0018);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    step(0, 0, 1, 32'h7FFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_user", imem_addr, 32'h0000_0000);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_sup", imem_addr, 32'h8000_0000);
    chk("wrap_sup_pc4", pc4_out, 32'h8000_0000);

    step(0, 0, 1, 32'h0000_0020, 0);
    step(0, 1, 0, 0, 0);
    chk("flush_addr", imem_addr, 32'h0000_0024);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_pc_out", pc_out, 32'h0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("stall_flush_addr", imem_addr, 32'h0000_0028);
    chk("stall_flush_valid", {31'd0, valid_out}, 32'd0);

    // irq-to-entry latency, measured in cycles from assertion.
    step(0, 0, 1, 32'h0000_0200, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 0, 1);
      if (irq_out && lat < 0) lat = i;
    end
    chk("irq_latency", lat, EXP_LAT);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      rt = $urandom;
      step($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, rt, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset between edges.
    irq = 1'b0; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset", m_slot, RESET_PC);
    #1 reset = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_reset_addr", imem_addr, 32'h8000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
